// File: rtl/servo_pkg.sv
// servo_pkg: shared state encoding and pulse-width arithmetic for the servo scheduler.
//   POS_W_DEF  : default position word width
//   centre_pos : centre position constant (2^(pos_w-1)) for a given word width
//   state_e    : scheduler states
//   calc_width : position -> pulse width in microsecond ticks
package servo_pkg;

  localparam int unsigned POS_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Centre position: the MSB alone, giving MIN + SPAN/2.
  function automatic logic [31:0] centre_pos(input int unsigned pos_w);
    return 32'(1) << (pos_w - 1);
  endfunction

  // width = min_us + (pos * span_us) >> pos_w, full-precision product, truncating.
  function automatic logic [31:0] calc_width(input logic [31:0] pos,
                                             input int unsigned min_us,
                                             input int unsigned span_us,
                                             input int unsigned pos_w);
    logic [63:0] prod;
    prod = 64'(pos) * 64'(span_us);
    return min_us + 32'(prod >> pos_w);
  endfunction

endpackage

// File: rtl/servo_pwm_scheduler_tick_gen.sv
// tick_gen: microsecond prescaler for the servo scheduler.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of the prescaler
//   tick_c   : combinational one-cycle pulse while the count equals CLK_DIV-1
module tick_gen #(
  parameter int unsigned CLK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] presc_q;
  logic [CNT_W-1:0] presc_d;

  assign tick_c = (presc_q == CNT_W'(CLK_DIV - 1));

  // Count 0..CLK_DIV-1 and wrap; clear wins.
  always_comb begin
    presc_d = presc_q + CNT_W'(1);
    if (clr || tick_c) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/servo_pwm_scheduler.sv
// servo_pwm_scheduler: time-slotted servo pulse generator sharing one timebase
// and one pulse timer across N_CH channels, with double-buffered positions.
//   clk, rst        : 100 MHz clock, asynchronous active-high reset
//   en              : run enable; low forces IDLE
//   wr_valid/ready  : position write handshake (ready low only in LOAD)
//   wr_ch, wr_pos   : target channel and position
//   wr_err          : one-cycle pulse after an accepted out-of-range write
//   servo_o         : registered servo pulse outputs
//   frame_start     : high during the LOAD cycle
//   busy            : high whenever the scheduler is not IDLE
module servo_pwm_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 100,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned FRAME_US = 20000,
  parameter int unsigned MIN_US   = 1000,
  parameter int unsigned SPAN_US  = 1000,
  parameter int unsigned POS_W    = POS_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(N_CH)-1:0] wr_ch,
  input  logic [POS_W-1:0]        wr_pos,
  output logic                    wr_err,
  output logic [N_CH-1:0]         servo_o,
  output logic                    frame_start,
  output logic                    busy
);

  localparam int unsigned CH_W    = $clog2(N_CH);
  localparam int unsigned SLOT_US = FRAME_US / N_CH;
  localparam int unsigned CNT_W   = $clog2(SLOT_US);
  localparam logic [POS_W-1:0] CENTRE = POS_W'(centre_pos(POS_W));

  state_e state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [POS_W-1:0] shadow_q [N_CH];
  logic [POS_W-1:0] shadow_d [N_CH];
  logic [POS_W-1:0] active_q [N_CH];
  logic [POS_W-1:0] active_d [N_CH];

  logic [N_CH-1:0] servo_q, servo_d;
  logic            frame_start_q, frame_start_d;
  logic            busy_q, busy_d;
  logic            wr_ready_q, wr_ready_d;
  logic            wr_err_q, wr_err_d;

  logic        tick_c;
  logic        clr_c;
  logic        accept_c;
  logic        in_range_c;
  logic [31:0] width_c;

  assign clr_c      = (state_q == IDLE) || (state_q == LOAD);
  assign accept_c   = wr_valid && wr_ready_q;
  assign in_range_c = (32'(wr_ch) < N_CH);
  assign width_c    = calc_width(32'(active_q[ch_q]), MIN_US, SPAN_US, POS_W);

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_c),
    .tick_c (tick_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the shared slot timer and channel pointer.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    slot_cnt_d = slot_cnt_q;
    case (state_q)
      IDLE: begin
        ch_d       = '0;
        slot_cnt_d = '0;
        if (en) state_d = LOAD;
      end
      LOAD: begin
        ch_d       = '0;
        slot_cnt_d = '0;
        state_d    = PULSE;
      end
      PULSE: begin
        if (tick_c) begin
          slot_cnt_d = slot_cnt_q + CNT_W'(1);
          if (32'(slot_cnt_q) == width_c - 32'd1) state_d = GAP;
        end
      end
      GAP: begin
        if (tick_c) begin
          if (slot_cnt_q == CNT_W'(SLOT_US - 1)) begin
            if (ch_q == CH_W'(N_CH - 1)) begin
              state_d = LOAD;
            end else begin
              ch_d       = ch_q + CH_W'(1);
              slot_cnt_d = '0;
              state_d    = PULSE;
            end
          end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable aborts from any state; a pulse in flight is truncated.
    if (!en) state_d = IDLE;
  end

  // Registered outputs decoded from the upcoming state.
  always_comb begin
    servo_d       = '0;
    frame_start_d = (state_d == LOAD);
    busy_d        = (state_d != IDLE);
    wr_ready_d    = (state_d != LOAD);
    wr_err_d      = accept_c && !in_range_c;
    if (state_d == PULSE) servo_d[ch_d] = 1'b1;
  end

  // Shadow takes writes any time; active only reloads in LOAD.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (accept_c && in_range_c) shadow_d[wr_ch] = wr_pos;
    if (state_q == LOAD) active_d = shadow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q          <= '0;
      slot_cnt_q    <= '0;
      shadow_q      <= '{default: CENTRE};
      active_q      <= '{default: CENTRE};
      servo_q       <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      wr_ready_q    <= 1'b1;
      wr_err_q      <= 1'b0;
    end else begin
      ch_q          <= ch_d;
      slot_cnt_q    <= slot_cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      servo_q       <= servo_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      wr_ready_q    <= wr_ready_d;
      wr_err_q      <= wr_err_d;
    end
  end

  assign servo_o     = servo_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign wr_ready    = wr_ready_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Directed bench: dut_a uses CLK_DIV=4, N_CH=4, FRAME_US=8000 (slot 2000 ticks);
// dut_b uses CLK_DIV=1, N_CH=5, FRAME_US=10000 so a 3-bit wr_ch can be out of range.
module tb_servo_pwm_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, wr_valid, wr_ready, wr_err, frame_start, busy;
  logic [1:0] wr_ch;
  logic [7:0] wr_pos;
  logic [3:0] servo_o;

  logic       en_b, wr_valid_b, wr_ready_b, wr_err_b, frame_start_b, busy_b;
  logic [2:0] wr_ch_b;
  logic [7:0] wr_pos_b;
  logic [4:0] servo_b;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned f1, f2, f3, fl, fr, tb_t;
  bit          ok;

  int unsigned rise_a [4];
  int unsigned hi_a [4];
  logic [3:0]  prev_a = '0;
  int unsigned rise_b [5];
  int unsigned hi_b [5];
  logic [4:0]  prev_b = '0;

  servo_pwm_scheduler #(.CLK_DIV(4), .N_CH(4), .FRAME_US(8000), .MIN_US(1000),
                        .SPAN_US(1000), .POS_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_pos(wr_pos), .wr_err(wr_err), .servo_o(servo_o),
    .frame_start(frame_start), .busy(busy));

  servo_pwm_scheduler #(.CLK_DIV(1), .N_CH(5), .FRAME_US(10000), .MIN_US(1000),
                        .SPAN_US(1000), .POS_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .wr_ch(wr_ch_b), .wr_pos(wr_pos_b), .wr_err(wr_err_b), .servo_o(servo_b),
    .frame_start(frame_start_b), .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record rise cycle and high time of every pulse on both DUTs.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (servo_o[c] === 1'b1 && prev_a[c] === 1'b0) rise_a[c] = cyc;
      if (servo_o[c] === 1'b0 && prev_a[c] === 1'b1) hi_a[c] = cyc - rise_a[c];
    end
    prev_a = servo_o;
    for (int c = 0; c < 5; c++) begin
      if (servo_b[c] === 1'b1 && prev_b[c] === 1'b0) rise_b[c] = cyc;
      if (servo_b[c] === 1'b0 && prev_b[c] === 1'b1) hi_b[c] = cyc - rise_b[c];
    end
    prev_b = servo_b;
  end

  task automatic wait_frame(input bit sel, output int unsigned t, output bit found);
    found = 1'b0;
    t = cyc;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if ((sel ? frame_start_b : frame_start) === 1'b1) begin
        found = 1'b1;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_pos = '0;
    en_b = 1'b0; wr_valid_b = 1'b0; wr_ch_b = '0; wr_pos_b = '0;
    repeat (3) @(negedge clk);
    total++; if (servo_o !== 4'b0000) begin bad++; $display("FAIL reset_servo got=%b want=0000", servo_o); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%b want=0", frame_start); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL reset_wr_err got=%b want=0", wr_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_wr_err;
    total++; if (wr_ready_b !== 1'b1) begin bad++; $display("FAIL err_ready got=%b want=1", wr_ready_b); end
    wr_valid_b = 1'b1; wr_ch_b = 3'd5; wr_pos_b = 8'd0;
    @(negedge clk);
    wr_valid_b = 1'b0;
    total++; if (wr_err_b !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b want=1", wr_err_b); end
    @(negedge clk);
    total++; if (wr_err_b !== 1'b0) begin bad++; $display("FAIL err_once got=%b want=0", wr_err_b); end
    wr_valid_b = 1'b1; wr_ch_b = 3'd4; wr_pos_b = 8'd255;
    @(negedge clk);
    wr_valid_b = 1'b0;
    total++; if (wr_err_b !== 1'b0) begin bad++; $display("FAIL err_inrange got=%b want=0", wr_err_b); end
    en_b = 1'b1;
    wait_frame(1'b1, tb_t, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL err_frame_timeout got=%b want=1", ok); end
    wait_until(tb_t + 3503);
    total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL err_busy got=%b want=1", busy_b); end
    total++; if (hi_b[0] !== 32'd1500) begin bad++; $display("FAIL err_ch0_width got=%0d want=1500", hi_b[0]); end
    total++; if (hi_b[1] !== 32'd1500) begin bad++; $display("FAIL err_ch1_width got=%0d want=1500", hi_b[1]); end
    total++; if (rise_b[1] - tb_t !== 32'd2001) begin bad++; $display("FAIL err_ch1_offset got=%0d want=2001", rise_b[1] - tb_t); end
    en_b = 1'b0;
  endtask

  task automatic test_mid_frame_write;
    en = 1'b1;
    wait_frame(1'b0, f1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL f1_timeout got=%b want=1", ok); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL load_busy got=%b want=1", busy); end
    total++; if (servo_o !== 4'b0000) begin bad++; $display("FAIL load_servo got=%b want=0000", servo_o); end
    repeat (1000) @(negedge clk);
    total++; if (servo_o !== 4'b0001) begin bad++; $display("FAIL ch0_high got=%b want=0001", servo_o); end
    wr_valid = 1'b1; wr_ch = 2'd1; wr_pos = 8'd0;
    @(negedge clk);
    wr_ch = 2'd2; wr_pos = 8'd255;
    @(negedge clk);
    wr_valid = 1'b0;
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL mid_wr_err got=%b want=0", wr_err); end
  endtask

  task automatic test_centre_frame;
    wait_frame(1'b0, f2, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL f2_timeout got=%b want=1", ok); end
    total++; if (f2 - f1 !== 32'd32001) begin bad++; $display("FAIL frame_period got=%0d want=32001", f2 - f1); end
    total++; if (rise_a[0] - f1 !== 32'd1) begin bad++; $display("FAIL ch0_rise got=%0d want=1", rise_a[0] - f1); end
    for (int c = 1; c < 4; c++) begin
      total++;
      if (rise_a[c] - rise_a[0] !== 32'(c) * 32'd8000) begin
        bad++; $display("FAIL slot_offset ch%0d got=%0d want=%0d", c, rise_a[c] - rise_a[0], c * 8000);
      end
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (hi_a[c] !== 32'd6000) begin
        bad++; $display("FAIL centre_width ch%0d got=%0d want=6000", c, hi_a[c]);
      end
    end
  endtask

  task automatic test_load_stall;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL load_ready got=%b want=0", wr_ready); end
    wr_valid = 1'b1; wr_ch = 2'd0; wr_pos = 8'd0;
    @(negedge clk);
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL post_load_ready got=%b want=1", wr_ready); end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_new_widths;
    wait_until(f2 + 24002);
    total++; if (rise_a[0] - f2 !== 32'd1) begin bad++; $display("FAIL f2_ch0_rise got=%0d want=1", rise_a[0] - f2); end
    total++; if (hi_a[0] !== 32'd6000) begin bad++; $display("FAIL held_write_early got=%0d want=6000", hi_a[0]); end
    total++; if (hi_a[1] !== 32'd4000) begin bad++; $display("FAIL pos0_width got=%0d want=4000", hi_a[1]); end
    total++; if (hi_a[2] !== 32'd7984) begin bad++; $display("FAIL pos255_width got=%0d want=7984", hi_a[2]); end
    total++; if (rise_a[2] - f2 !== 32'd16001) begin bad++; $display("FAIL ch2_rise got=%0d want=16001", rise_a[2] - f2); end
  endtask

  task automatic test_enable_drop;
    wait_frame(1'b0, f3, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL f3_timeout got=%b want=1", ok); end
    total++; if (f3 - f2 !== 32'd32001) begin bad++; $display("FAIL frame_period2 got=%0d want=32001", f3 - f2); end
    repeat (2000) @(negedge clk);
    total++; if (servo_o !== 4'b0001) begin bad++; $display("FAIL pre_drop_servo got=%b want=0001", servo_o); end
    en = 1'b0;
    @(negedge clk);
    total++; if (servo_o !== 4'b0000) begin bad++; $display("FAIL drop_servo got=%b want=0000", servo_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b want=0", busy); end
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL restart_load got=%b want=1", frame_start); end
    fl = cyc;
    wait_until(fl + 4002);
    total++; if (rise_a[0] - fl !== 32'd1) begin bad++; $display("FAIL restart_rise got=%0d want=1", rise_a[0] - fl); end
    total++; if (hi_a[0] !== 32'd4000) begin bad++; $display("FAIL restart_width got=%0d want=4000", hi_a[0]); end
  endtask

  task automatic test_async_reset;
    repeat (100) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=%b want=1", busy); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
    total++; if (servo_o !== 4'b0000) begin bad++; $display("FAIL arst_servo got=%b want=0000", servo_o); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want=1", wr_ready); end
    @(negedge clk);
    rst = 1'b0;
    wait_frame(1'b0, fr, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL post_rst_timeout got=%b want=1", ok); end
    wait_until(fr + 6002);
    total++; if (rise_a[0] - fr !== 32'd1) begin bad++; $display("FAIL post_rst_rise got=%0d want=1", rise_a[0] - fr); end
    total++; if (hi_a[0] !== 32'd6000) begin bad++; $display("FAIL post_rst_width got=%0d want=6000", hi_a[0]); end
  endtask

  initial begin
    test_reset();
    test_wr_err();
    test_mid_frame_write();
    test_centre_frame();
    test_load_stall();
    test_new_widths();
    test_enable_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
